ps2_scancode_decoder: RTL and testbench

Consumes raw bytes from the PS/2 receiver through its dsr/rden handshake and decodes Set-2 prefix sequences (E0, F0, E1 Pause) into single key events {ext, release, code}. Error and control bytes are filtered out. Events are buffered in a small show-ahead FIFO for the keyboard-matrix mapper, which pops them with ev_ack. This block sits between the PS/2 receiver and the Vector-06C keyboard matrix logic.

---
 rtl/ps2_pkg.sv | 42 ++++
 rtl/ps2_scancode_decoder_if.sv | 27 ++
 rtl/ps2_event_fifo.sv | 46 ++++
 rtl/ps2_scancode_decoder.sv | 135 +++++++++++++
 tb/tb_ps2_scancode_decoder.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 scancode decoder.
//   - Set-2 special byte values (prefixes, receiver error markers, control replies)
//   - ps2_event_t: 10-bit key event record {ext, rel, code}
//   - ps2_state_t: fetch/decode FSM encoding
//   - small byte classification helpers
package ps2_pkg;

   localparam logic [7:0] PS2_EXT    = 8'hE0;
   localparam logic [7:0] PS2_REL    = 8'hF0;
   localparam logic [7:0] PS2_PAUSE  = 8'hE1;
   localparam logic [7:0] PS2_ERR    = 8'hFF;
   localparam logic [7:0] PS2_OVR    = 8'h00;
   localparam logic [7:0] PS2_BAT    = 8'hAA;
   localparam logic [7:0] PS2_ACK    = 8'hFA;
   localparam logic [7:0] PS2_RESEND = 8'hFE;
   localparam logic [7:0] PS2_ECHO   = 8'hEE;

   // Pause make is E1 14 77 E1 F0 14 F0 77: seven bytes follow the leading E1.
   localparam logic [2:0] PAUSE_SKIP_LEN = 3'd7;

   typedef struct packed {
      logic       ext;
      logic       rel;
      logic [7:0] code;
   } ps2_event_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FETCH  = 2'd1,
      DECODE = 2'd2
   } ps2_state_t;

   function automatic logic is_err_byte(input logic [7:0] b);
      return (b == PS2_ERR) || (b == PS2_OVR);
   endfunction

   // Keyboard replies to host commands; never key events.
   function automatic logic is_ctrl_byte(input logic [7:0] b);
      return (b == PS2_BAT) || (b == PS2_ACK) || (b == PS2_RESEND) || (b == PS2_ECHO);
   endfunction

endpackage

// File: rtl/ps2_scancode_decoder_if.sv
// ps2_scancode_decoder_if: receiver-side and event-side signals of the decoder.
//   rx_q/rx_dsr/rx_rden : byte read handshake with the PS/2 receiver
//   ev_*                : show-ahead key event stream toward the matrix mapper
//   overflow/err_count  : status
// Modports: master = the decoder, slave = its environment.
interface ps2_scancode_decoder_if;
   logic [7:0] rx_q;
   logic       rx_dsr;
   logic       rx_rden;
   logic       ev_valid;
   logic [7:0] ev_code;
   logic       ev_ext;
   logic       ev_release;
   logic       ev_ack;
   logic       overflow;
   logic [3:0] err_count;

   modport master (
      input  rx_q, rx_dsr, ev_ack,
      output rx_rden, ev_valid, ev_code, ev_ext, ev_release, overflow, err_count
   );

   modport slave (
      output rx_q, rx_dsr, ev_ack,
      input  rx_rden, ev_valid, ev_code, ev_ext, ev_release, overflow, err_count
   );
endinterface

// File: rtl/ps2_event_fifo.sv
// ps2_event_fifo: show-ahead synchronous FIFO, depth 2**AW, width W.
//   push/din  : write request (accepted when not full, or when full and popping)
//   pop       : read request (ignored when empty)
//   dout      : head entry, valid while empty=0
//   full/empty: status flags from AW+1 bit wrapping pointers
module ps2_event_fifo #(
   parameter int W  = 10,
   parameter int AW = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);
   localparam int DEPTH = 1 << AW;

   logic [DEPTH-1:0][W-1:0] mem;
   logic [AW:0]             wr_ptr, rd_ptr;
   logic                    rd_en, wr_en;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign rd_en = pop && !empty;
   // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
   assign wr_en = push && (!full || rd_en);
   assign dout  = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (reset) begin
         mem    <= '0;   // keeps the head defined (not X) while empty
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= din;
            wr_ptr              <= wr_ptr + (AW+1)'(1);
         end
         if (rd_en)
            rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end
endmodule

// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder: pulls bytes from the PS/2 receiver and folds Set-2
// prefix sequences (E0, F0, E1 Pause) into single {ext, release, code} events,
// buffered in a show-ahead FIFO.
//   clk, reset : clock, synchronous active-high reset
//   bus.rx_*   : receiver handshake (rx_rden one-cycle strobe, rx_q valid next cycle)
//   bus.ev_*   : head event and ack (pop)
//   bus.overflow  : sticky, an event was dropped on a full FIFO
//   bus.err_count : saturating count of FF/00 bytes
module ps2_scancode_decoder
   import ps2_pkg::*;
#(
   parameter int         FIFO_AW    = 2,
   parameter logic [7:0] PAUSE_CODE = 8'h77
) (
   input  logic                          clk,
   input  logic                          reset,
   ps2_scancode_decoder_if.master        bus
);

   ps2_state_t state_q, state_d;
   logic       ext_q, ext_d;
   logic       rel_q, rel_d;
   logic [2:0] skip_q, skip_d;
   logic [3:0] err_q;
   logic       err_inc;
   logic       ovf_q;
   logic       push, pop, full, empty;
   ps2_event_t push_ev, head;

   // ---------------- fetch/decode FSM ----------------
   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (bus.rx_dsr) state_d = FETCH;
         FETCH:   state_d = DECODE;
         DECODE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Strobe decoded from registered state: one cycle wide, never back to back,
   // and low throughout reset. The receiver loads rx_q on this edge, so rx_q is
   // valid in DECODE.
   assign bus.rx_rden = (state_q == FETCH);

   // ---------------- byte classification ----------------
   always_comb begin
      ext_d   = ext_q;
      rel_d   = rel_q;
      skip_d  = skip_q;
      err_inc = 1'b0;
      push    = 1'b0;
      push_ev = '0;
      if (state_q == DECODE) begin
         if (is_err_byte(bus.rx_q)) begin
            // Errors always resync: drop prefixes and abort any Pause skip.
            ext_d   = 1'b0;
            rel_d   = 1'b0;
            skip_d  = '0;
            err_inc = 1'b1;
         end else if (skip_q != '0) begin
            skip_d = skip_q - 3'd1;
            if (skip_q == 3'd1) begin
               push    = 1'b1;
               push_ev = '{ext: 1'b1, rel: 1'b0, code: PAUSE_CODE};
            end
         end else if (bus.rx_q == PS2_EXT) begin
            ext_d = 1'b1;
         end else if (bus.rx_q == PS2_REL) begin
            rel_d = 1'b1;
         end else if (bus.rx_q == PS2_PAUSE) begin
            ext_d  = 1'b0;
            rel_d  = 1'b0;
            skip_d = PAUSE_SKIP_LEN;
         end else if (is_ctrl_byte(bus.rx_q)) begin
            ext_d = 1'b0;
            rel_d = 1'b0;
         end else begin
            push    = 1'b1;
            push_ev = '{ext: ext_q, rel: rel_q, code: bus.rx_q};
            ext_d   = 1'b0;
            rel_d   = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ext_q  <= 1'b0;
         rel_q  <= 1'b0;
         skip_q <= '0;
         err_q  <= '0;
         ovf_q  <= 1'b0;
      end else begin
         ext_q  <= ext_d;
         rel_q  <= rel_d;
         skip_q <= skip_d;
         if (err_inc && (err_q != 4'hF))
            err_q <= err_q + 4'd1;
         // Dropped only when full and no pop frees a slot this cycle.
         if (push && full && !pop)
            ovf_q <= 1'b1;
      end
   end

   // ---------------- event FIFO ----------------
   assign pop = bus.ev_ack && !empty;

   ps2_event_fifo #(
      .W  ($bits(ps2_event_t)),
      .AW (FIFO_AW)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .din   (push_ev),
      .pop   (pop),
      .dout  (head),
      .full  (full),
      .empty (empty)
   );

   assign bus.ev_valid   = !empty;
   assign bus.ev_code    = head.code;
   assign bus.ev_ext     = head.ext;
   assign bus.ev_release = head.rel;
   assign bus.overflow   = ovf_q;
   assign bus.err_count  = err_q;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench for ps2_scancode_decoder: a behavioural receiver feeds bytes
// through the dsr/rden handshake; event outputs are compared against
// hand-computed expectations.
module tb_ps2_scancode_decoder;
   logic clk = 1'b0;
   logic reset;
   int   n_chk = 0;
   int   n_err = 0;

   ps2_scancode_decoder_if bus ();

   ps2_scancode_decoder #(.FIFO_AW(2), .PAUSE_CODE(8'h77)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Receiver model: raise dsr, wait for the rden strobe, present the byte.
   task automatic send_byte(input logic [7:0] b);
      bit got = 1'b0;
      @(negedge clk);
      bus.rx_dsr = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (bus.rx_rden) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) chk("rden_timeout", 32'd0, 32'd1);
      bus.rx_q   = b;
      bus.rx_dsr = 1'b0;
   endtask

   task automatic settle();
      repeat (2) @(negedge clk);
   endtask

   task automatic pop_ev();
      @(negedge clk);
      bus.ev_ack = 1'b1;
      @(negedge clk);
      bus.ev_ack = 1'b0;
   endtask

   task automatic chk_ev(input string tag, input logic [7:0] code, input logic ext, input logic rel);
      chk({tag, "_valid"}, 32'(bus.ev_valid), 32'd1);
      chk({tag, "_code"},  32'(bus.ev_code), 32'(code));
      chk({tag, "_ext"},   32'(bus.ev_ext), 32'(ext));
      chk({tag, "_rel"},   32'(bus.ev_release), 32'(rel));
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_rden"},  32'(bus.rx_rden), 32'd0);
      chk({tag, "_valid"}, 32'(bus.ev_valid), 32'd0);
      chk({tag, "_code"},  32'(bus.ev_code), 32'd0);
      chk({tag, "_ext"},   32'(bus.ev_ext), 32'd0);
      chk({tag, "_rel"},   32'(bus.ev_release), 32'd0);
      chk({tag, "_ovf"},   32'(bus.overflow), 32'd0);
      chk({tag, "_err"},   32'(bus.err_count), 32'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      chk_reset_vals("in_reset");
      reset = 1'b0;
   endtask

   initial begin
      logic [7:0] pause_seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
      bus.rx_q   = 8'h00;
      bus.rx_dsr = 1'b0;
      bus.ev_ack = 1'b0;
      reset      = 1'b1;
      repeat (3) @(negedge clk);
      chk_reset_vals("reset");
      reset = 1'b0;

      // Plain make code, single rden pulse
      send_byte(8'h1C);
      @(negedge clk);
      chk("rden_single", 32'(bus.rx_rden), 32'd0);
      @(negedge clk);
      chk_ev("make_1c", 8'h1C, 1'b0, 1'b0);
      pop_ev();
      chk("make_1c_popped", 32'(bus.ev_valid), 32'd0);

      // Extended release: E0 F0 75
      send_byte(8'hE0);
      send_byte(8'hF0);
      settle();
      chk("prefix_no_event", 32'(bus.ev_valid), 32'd0);
      send_byte(8'h75);
      settle();
      chk_ev("ext_rel_75", 8'h75, 1'b1, 1'b1);
      pop_ev();
      chk("ext_rel_one", 32'(bus.ev_valid), 32'd0);

      // Pause sequence collapses to one event, then normal decoding resumes
      foreach (pause_seq[i]) send_byte(pause_seq[i]);
      settle();
      chk_ev("pause", 8'h77, 1'b1, 1'b0);
      pop_ev();
      chk("pause_one", 32'(bus.ev_valid), 32'd0);
      send_byte(8'h1C);
      settle();
      chk_ev("after_pause", 8'h1C, 1'b0, 1'b0);
      pop_ev();

      // Control byte clears pending release prefix
      send_byte(8'hF0);
      send_byte(8'hAA);
      send_byte(8'h1C);
      settle();
      chk_ev("ctrl_clears", 8'h1C, 1'b0, 1'b0);
      pop_ev();
      chk("ctrl_no_event", 32'(bus.ev_valid), 32'd0);

      // Error inside Pause skip aborts it
      send_byte(8'hE1);
      send_byte(8'h14);
      send_byte(8'h00);
      send_byte(8'h1C);
      settle();
      chk("skip_abort_err", 32'(bus.err_count), 32'd1);
      chk_ev("skip_abort", 8'h1C, 1'b0, 1'b0);
      pop_ev();

      // Error clears E0 prefix
      send_byte(8'hE0);
      send_byte(8'hFF);
      send_byte(8'h1C);
      settle();
      chk("err_cnt_2", 32'(bus.err_count), 32'd2);
      chk_ev("err_clears_ext", 8'h1C, 1'b0, 1'b0);
      pop_ev();

      // Saturation
      for (int i = 0; i < 16; i++) send_byte(8'hFF);
      settle();
      chk("err_saturate", 32'(bus.err_count), 32'd15);
      chk("err_no_event", 32'(bus.ev_valid), 32'd0);

      // Reset between E0 and 75 discards the prefix
      send_byte(8'hE0);
      settle();
      do_reset();
      send_byte(8'h75);
      settle();
      chk_ev("reset_mid", 8'h75, 1'b0, 1'b0);

      // FIFO fill, simultaneous push/pop when full, overflow on drop
      do_reset();
      for (int i = 1; i <= 4; i++) send_byte(8'(i));
      settle();
      chk_ev("fifo_full_head", 8'h01, 1'b0, 1'b0);
      chk("fifo_no_ovf", 32'(bus.overflow), 32'd0);
      send_byte(8'h05);              // returns in FETCH; ack lands in DECODE
      @(negedge clk);
      bus.ev_ack = 1'b1;
      @(negedge clk);
      bus.ev_ack = 1'b0;
      chk("pushpop_full_ovf", 32'(bus.overflow), 32'd0);
      chk_ev("pushpop_head", 8'h02, 1'b0, 1'b0);
      send_byte(8'h06);
      settle();
      chk("overflow_set", 32'(bus.overflow), 32'd1);
      for (int i = 2; i <= 5; i++) begin
         chk_ev($sformatf("drain_%0d", i), 8'(i), 1'b0, 1'b0);
         pop_ev();
      end
      chk("drain_empty", 32'(bus.ev_valid), 32'd0);
      pop_ev();                      // ack while empty is ignored
      chk("ack_empty", 32'(bus.ev_valid), 32'd0);
      chk("overflow_sticky", 32'(bus.overflow), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule
